// File: rtl/main_data_scheduler.sv
// Walks the main-data parser through each granule/channel unit of a frame and drains unused bits between units.
// p_start follows side_info by two cycles; drain stalls on an empty bit FIFO; abort and overrun are registered pulses.
module main_data_scheduler #(
  parameter int MAX_CH = 2,
  parameter int LEN_W  = 12
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  header_iv,
  input  logic                  side_info_iv,
  input  logic                  mono_in,
  input  logic [3:0][LEN_W-1:0] part23_len_in,
  input  logic                  bit_valid_in,
  input  logic                  parser_rd_in,
  input  logic                  p_done_in,
  output logic                  p_start_out,
  output logic                  p_abort_out,
  output logic                  gr_out,
  output logic                  ch_out,
  output logic                  drain_rd_out,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic                  overrun_err_out
);

  localparam int UW = $clog2(2 * MAX_CH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_START,
    S_RUN,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                state_q, state_nxt;
  logic [3:0][LEN_W-1:0] len_q;
  logic                  mono_q;
  logic [UW-1:0]         unit_q;
  logic [LEN_W-1:0]      cnt_q, cnt_nxt, cur_len;
  logic [1:0]            len_idx;
  logic                  abort, pop, last_unit;
  logic                  abort_q, overrun_q;

  assign abort     = header_iv && (state_q != S_IDLE);
  // Mono units 0/1 are granules 0/1 of channel 0, i.e. length slots 0 and 2.
  assign len_idx   = mono_q ? {unit_q[0], 1'b0} : unit_q[1:0];
  assign cur_len   = len_q[len_idx];
  assign last_unit = mono_q ? (unit_q == UW'(1)) : (unit_q == UW'(2 * MAX_CH - 1));

  assign drain_rd_out = (state_q == S_DRAIN) && bit_valid_in && (cnt_q < cur_len);
  assign pop          = ((state_q == S_RUN) && bit_valid_in && parser_rd_in) || drain_rd_out;
  assign cnt_nxt      = (pop && (cnt_q != '1)) ? cnt_q + LEN_W'(1) : cnt_q;

  assign p_start_out     = (state_q == S_START);
  assign gr_out          = mono_q ? unit_q[0] : unit_q[1];
  assign ch_out          = mono_q ? 1'b0 : unit_q[0];
  assign busy_out        = (state_q != S_IDLE);
  assign frame_done_out  = (state_q == S_DONE);
  assign p_abort_out     = abort_q;
  assign overrun_err_out = overrun_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (side_info_iv) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_START;
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        if (p_done_in) state_nxt = (cnt_nxt < cur_len) ? S_DRAIN : S_NEXT;
      end
      S_DRAIN: if (cnt_nxt == cur_len) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = last_unit ? S_DONE : S_START;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      len_q     <= '0;
      mono_q    <= 1'b0;
      unit_q    <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      abort_q   <= abort;
      overrun_q <= !abort && (state_q == S_RUN) && p_done_in && (cnt_nxt > cur_len);
      if (abort) begin
        unit_q <= '0;
        cnt_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (side_info_iv) begin
              len_q  <= part23_len_in;
              mono_q <= mono_in;
            end
          end
          S_LATCH: begin
            unit_q <= '0;
            cnt_q  <= '0;
          end
          S_RUN, S_DRAIN: cnt_q <= cnt_nxt;
          S_NEXT: begin
            cnt_q <= '0;
            if (!last_unit) unit_q <= unit_q + UW'(1);
          end
          S_DONE: unit_q <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule
